// File: rtl/hc04_pkg.sv
// Shared types and default timing constants for HC-SR04 ranger channels.
package hc04_pkg;

   // Width of the reported echo measurement in us.
   localparam int unsigned ECHO_W = 16;
   // Width of the per-state us counter; wide enough for any 16-bit limit plus headroom.
   localparam int unsigned US_W   = 17;

   // Default timing, shared by every ranger instance and the bench.
   localparam int unsigned DEF_CLK_DIV         = 50;     // 50 MHz clock -> 1 us tick
   localparam int unsigned DEF_TRIG_US         = 12;     // sensor needs >= 10 us strobe
   localparam int unsigned DEF_RISE_TIMEOUT_US = 1000;
   localparam int unsigned DEF_MAX_ECHO_US     = 30000;
   localparam int unsigned DEF_HOLDOFF_US      = 60000;

   typedef enum logic [2:0] {
      StIdle,
      StTrig,
      StWaitRise,
      StMeasure,
      StDone,
      StHoldoff
   } state_e;

endpackage

// File: rtl/hc04_ranger_us_tick_gen.sv
// Microsecond prescaler: counts 0..CLK_DIV-1 and flags the last count as a tick.
// A synchronous clear realigns the tick phase to the cycle after clr.
module us_tick_gen #(
   parameter int unsigned CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   // Prescaler count; wraps on tick, restarts on clear.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hc04_ranger.sv
// HC-SR04 channel controller: issues the trigger strobe, times the echo pulse in us
// and reports the result with a one-cycle done strobe.
module hc04_ranger
   import hc04_pkg::*;
#(
   parameter int unsigned CLK_DIV         = DEF_CLK_DIV,
   parameter int unsigned TRIG_US         = DEF_TRIG_US,
   parameter int unsigned RISE_TIMEOUT_US = DEF_RISE_TIMEOUT_US,
   parameter int unsigned MAX_ECHO_US     = DEF_MAX_ECHO_US,
   parameter int unsigned HOLDOFF_US      = DEF_HOLDOFF_US
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              hc04_trigger,
   input  logic              hc04_echo,
   output logic [ECHO_W-1:0] echo_us,
   output logic              done,
   output logic              timeout
);

   // Timed states leave on the tick that completes their last us, so the state
   // lasts exactly LIMIT*CLK_DIV cycles.
   localparam logic [US_W-1:0] TRIG_LAST = US_W'(TRIG_US - 1);
   localparam logic [US_W-1:0] RISE_LAST = US_W'(RISE_TIMEOUT_US - 1);
   localparam logic [US_W-1:0] HOLD_LAST = US_W'(HOLDOFF_US - 1);
   localparam logic [US_W-1:0] ECHO_MAX  = US_W'(MAX_ECHO_US);

   state_e state_q, state_d;

   logic [US_W-1:0]   us_cnt_q, us_cnt_d, us_cnt_inc;
   logic [ECHO_W-1:0] echo_us_q, echo_us_d;
   logic              timeout_q, timeout_d;
   logic              trig_q;
   logic              done_q;

   logic echo_meta_q, echo_s_q, echo_prev_q;
   logic echo_rise, echo_fall;
   logic tick;
   logic state_change;

   assign state_change = (state_d != state_q);
   assign us_cnt_inc   = us_cnt_q + US_W'(1);
   assign echo_rise    = echo_s_q & ~echo_prev_q;
   assign echo_fall    = ~echo_s_q & echo_prev_q;

   // Prescaler restarts on every state entry so each state's us count is aligned.
   us_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_change),
      .tick (tick)
   );

   // Two-flop synchronizer for the asynchronous echo, plus a delayed copy for edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         echo_meta_q <= 1'b0;
         echo_s_q    <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         echo_meta_q <= hc04_echo;
         echo_s_q    <= echo_meta_q;
         echo_prev_q <= echo_s_q;
      end
   end

   // Next-state, us counter and result capture.
   always_comb begin
      state_d   = state_q;
      us_cnt_d  = us_cnt_q;
      echo_us_d = echo_us_q;
      timeout_d = timeout_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StTrig;
            end
         end

         StTrig: begin
            if (tick) begin
               if (us_cnt_q == TRIG_LAST) begin
                  state_d = StWaitRise;
               end else begin
                  us_cnt_d = us_cnt_inc;
               end
            end
         end

         StWaitRise: begin
            // An echo already high when we got here never produces a rise.
            if (echo_rise) begin
               state_d = StMeasure;
            end else if (tick) begin
               if (us_cnt_q == RISE_LAST) begin
                  state_d   = StDone;
                  echo_us_d = '0;
                  timeout_d = 1'b1;
               end else begin
                  us_cnt_d = us_cnt_inc;
               end
            end
         end

         StMeasure: begin
            // Count against the delayed echo: it is high from the entry cycle through
            // the fall-detect cycle, i.e. exactly the echo_s high time, so the result
            // is floor(high_cycles / CLK_DIV).
            if (tick && echo_prev_q) begin
               us_cnt_d = us_cnt_inc;
            end
            if (us_cnt_d == ECHO_MAX) begin
               state_d   = StDone;
               echo_us_d = ECHO_W'(ECHO_MAX);
               timeout_d = 1'b1;
            end else if (echo_fall) begin
               state_d   = StDone;
               echo_us_d = ECHO_W'(us_cnt_d);
               timeout_d = 1'b0;
            end
         end

         StDone: begin
            state_d = StHoldoff;
         end

         StHoldoff: begin
            if (tick) begin
               if (us_cnt_q == HOLD_LAST) begin
                  state_d = StIdle;
               end else begin
                  us_cnt_d = us_cnt_inc;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_change) begin
         us_cnt_d = '0;
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         us_cnt_q  <= '0;
         echo_us_q <= '0;
         timeout_q <= 1'b0;
         trig_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         us_cnt_q  <= us_cnt_d;
         echo_us_q <= echo_us_d;
         timeout_q <= timeout_d;
         trig_q    <= (state_d == StTrig);
         done_q    <= (state_d == StDone);
      end
   end

   assign busy         = (state_q != StIdle);
   assign hc04_trigger = trig_q;
   assign echo_us      = echo_us_q;
   assign done         = done_q;
   assign timeout      = timeout_q;

endmodule
